// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong output reorder buffer for the streaming FFT core.
// Each incoming bin is written at its natural frequency index. Once a bank
// holds a full frame it is replayed in index order 0..N-1 under valid/ready,
// while the other bank collects the next frame.
module fft_reorder #(
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18,
    parameter int TOTAL_STAGE = 11
) (
    input  logic                   iclk,
    input  logic                   rst,
    input  logic                   ien,
    input  logic [TOTAL_STAGE-1:0] iaddr,
    input  logic [REAL_WIDTH-1:0]  iReal,
    input  logic [IMGN_WIDTH-1:0]  iImag,
    input  logic                   ordy,
    output logic                   oen,
    output logic [TOTAL_STAGE-1:0] oaddr,
    output logic [REAL_WIDTH-1:0]  oReal,
    output logic [IMGN_WIDTH-1:0]  oImag,
    output logic                   olast,
    output logic                   ovf
);

    localparam int DATA_WIDTH = REAL_WIDTH + IMGN_WIDTH;
    localparam int DEPTH      = 2 * (2 ** TOTAL_STAGE);
    localparam logic [TOTAL_STAGE-1:0] LAST_IDX = '1;
    localparam logic [TOTAL_STAGE-1:0] ONE_IDX  = TOTAL_STAGE'(1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} readState_t;

    // Both banks share one array; the top address bit selects the bank.
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [1:0]             full_q, full_d, fullAfterWr;
    logic                   wbank_q, wbank_d;
    logic                   rbank_q, rbank_d;
    logic [TOTAL_STAGE-1:0] wrCnt_q, wrCnt_d;
    logic                   ovf_q, ovf_d;
    readState_t             state_q, state_d;
    logic                   oen_q, oen_d;
    logic [TOTAL_STAGE-1:0] oaddr_q;
    logic [REAL_WIDTH-1:0]  oReal_q;
    logic [IMGN_WIDTH-1:0]  oImag_q;
    logic                   olast_q;

    logic                   wrAccept, wrDone;
    logic                   rdDone, rdLoad;
    logic [TOTAL_STAGE-1:0] rdIdx;
    logic [DATA_WIDTH-1:0]  rdWord;

    // Write side: accept beats into the write bank, close the frame on the Nth beat.
    always_comb begin
        wrAccept    = ien && !full_q[wbank_q];
        wrDone      = wrAccept && (wrCnt_q == LAST_IDX);
        wrCnt_d     = wrCnt_q;
        wbank_d     = wbank_q;
        ovf_d       = ovf_q;
        fullAfterWr = full_q;
        if (wrAccept) begin
            wrCnt_d = wrDone ? '0 : wrCnt_q + ONE_IDX;
        end
        if (wrDone) begin
            fullAfterWr[wbank_q] = 1'b1;
            wbank_d              = ~wbank_q;
        end
        if (ien && full_q[wbank_q]) begin
            ovf_d = 1'b1;
        end
    end

    // Full flags: the read side releases its bank after the last handshake.
    always_comb begin
        full_d = fullAfterWr;
        if (rdDone) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    // Read FSM next state: FETCH covers the RAM latency, STREAM walks indices.
    always_comb begin
        state_d = state_q;
        rbank_d = rbank_q;
        oen_d   = oen_q;
        rdDone  = 1'b0;
        rdLoad  = 1'b0;
        rdIdx   = '0;
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rdLoad  = 1'b1;
                rdIdx   = '0;
                oen_d   = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (ordy) begin
                    if (oaddr_q == LAST_IDX) begin
                        rdDone  = 1'b1;
                        rbank_d = ~rbank_q;
                        oen_d   = 1'b0;
                        state_d = fullAfterWr[~rbank_q] ? FETCH : IDLE;
                    end else begin
                        rdLoad = 1'b1;
                        rdIdx  = oaddr_q + ONE_IDX;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdWord = mem[{rbank_q, rdIdx}];

    // Frame RAM write port; contents are deliberately not reset.
    always_ff @(posedge iclk) begin
        if (wrAccept) begin
            mem[{wbank_q, iaddr}] <= {iReal, iImag};
        end
    end

    // Bank bookkeeping, overflow flag and read FSM state.
    always_ff @(posedge iclk) begin
        if (rst) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wrCnt_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wrCnt_q <= wrCnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    // Output registers double as the RAM read register; they only move on a load.
    always_ff @(posedge iclk) begin
        if (rst) begin
            oen_q   <= 1'b0;
            oaddr_q <= '0;
            oReal_q <= '0;
            oImag_q <= '0;
            olast_q <= 1'b0;
        end else begin
            oen_q <= oen_d;
            if (rdLoad) begin
                oaddr_q <= rdIdx;
                olast_q <= (rdIdx == LAST_IDX);
                oReal_q <= rdWord[DATA_WIDTH-1:IMGN_WIDTH];
                oImag_q <= rdWord[IMGN_WIDTH-1:0];
            end else if (rdDone) begin
                olast_q <= 1'b0;
            end
        end
    end

    assign oen   = oen_q;
    assign oaddr = oaddr_q;
    assign oReal = oReal_q;
    assign oImag = oImag_q;
    assign olast = olast_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed bench for fft_reorder with an 8-point frame.
// Every expected output beat is derived from the frame number and index:
// real = 10*index + 100*frame, imag = -(index + 16*frame).
module tb_fft_reorder;

    localparam int N = 8;

    logic        iclk;
    logic        rst;
    logic        ien;
    logic [2:0]  iaddr;
    logic [17:0] iReal;
    logic [17:0] iImag;
    logic        ordy;
    logic        oen;
    logic [2:0]  oaddr;
    logic [17:0] oReal;
    logic [17:0] oImag;
    logic        olast;
    logic        ovf;

    // Scrambled arrival order of the bins within every frame.
    int order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int hsCount     = 0;
    int expIdx      = 0;
    int expFrameQ [$];
    int startCyc  [$];
    logic prevOen   = 1'b0;
    int lastWr      = 0;
    int mark        = 0;

    fft_reorder #(
        .REAL_WIDTH (18),
        .IMGN_WIDTH (18),
        .TOTAL_STAGE(3)
    ) dut (
        .iclk (iclk),
        .rst  (rst),
        .ien  (ien),
        .iaddr(iaddr),
        .iReal(iReal),
        .iImag(iImag),
        .ordy (ordy),
        .oen  (oen),
        .oaddr(oaddr),
        .oReal(oReal),
        .oImag(oImag),
        .olast(olast),
        .ovf  (ovf)
    );

    // Free-running 10-unit clock.
    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    function automatic logic [17:0] expReal(input int f, input int a);
        return 18'(10 * a + 100 * f);
    endfunction

    function automatic logic [17:0] expImag(input int f, input int a);
        return 18'(-(a + 16 * f));
    endfunction

    // One comparison: counts it, and reports the tag with both values on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compares the presented beat with the head of the expected frame queue.
    task automatic checkStream();
        if (oen === 1'b1) begin
            if (!prevOen) startCyc.push_back(cyc);
            if (expFrameQ.size() == 0) begin
                checkOutput("spurious_oen", 32'(oen), 32'd0);
            end else begin
                checkOutput("oaddr", 32'(oaddr), 32'(expIdx));
                checkOutput("oReal", 32'(oReal), 32'(expReal(expFrameQ[0], expIdx)));
                checkOutput("oImag", 32'(oImag), 32'(expImag(expFrameQ[0], expIdx)));
                checkOutput("olast", 32'(olast), 32'(expIdx == N - 1));
            end
        end
        prevOen = (oen === 1'b1);
    endtask

    // Drives one cycle of inputs, books any handshake, then checks after the edge.
    task automatic applyStimulus(input logic ienV, input logic [2:0] addrV,
                                 input logic [17:0] reV, input logic [17:0] imV,
                                 input logic rdyV);
        ien   = ienV;
        iaddr = addrV;
        iReal = reV;
        iImag = imV;
        ordy  = rdyV;
        if (!rst && oen === 1'b1 && rdyV) begin
            hsCount++;
            expIdx++;
            if (expIdx == N) begin
                expIdx = 0;
                if (expFrameQ.size() > 0) void'(expFrameQ.pop_front());
            end
        end
        @(posedge iclk);
        #1;
        cyc++;
        checkStream();
    endtask

    task automatic idleCycle(input logic rdyV);
        applyStimulus(1'b0, 3'd0, 18'd0, 18'd0, rdyV);
    endtask

    task automatic writeFrame(input int f, input logic rdyV);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 3'(order[i]), expReal(f, order[i]), expImag(f, order[i]), rdyV);
        end
        lastWr = cyc;
    endtask

    // One-cycle reset pulse; all outputs must read zero right after it.
    task automatic resetDut(input string tag);
        rst = 1'b1;
        expFrameQ.delete();
        expIdx = 0;
        idleCycle(1'b1);
        checkOutput({tag, "_oen"},   32'(oen),   32'd0);
        checkOutput({tag, "_oaddr"}, 32'(oaddr), 32'd0);
        checkOutput({tag, "_oReal"}, 32'(oReal), 32'd0);
        checkOutput({tag, "_oImag"}, 32'(oImag), 32'd0);
        checkOutput({tag, "_olast"}, 32'(olast), 32'd0);
        checkOutput({tag, "_ovf"},   32'(ovf),   32'd0);
        rst = 1'b0;
        hsCount = 0;
        startCyc.delete();
    endtask

    // Runs ordy=1 until every expected frame has been consumed or the budget ends.
    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && expFrameQ.size() > 0; c++) idleCycle(1'b1);
        checkOutput(tag, 32'(expFrameQ.size()), 32'd0);
    endtask

    // Directed sequence of the whole test.
    initial begin
        rst = 1'b1; ien = 1'b0; iaddr = '0; iReal = '0; iImag = '0; ordy = 1'b0;
        $display("[TB] start");
        resetDut("rst0");

        // Single frame with ordy held high: latency, order, throughput.
        expFrameQ.push_back(0);
        writeFrame(0, 1'b1);
        checkOutput("t1_oen_lastwr", 32'(oen), 32'd0);
        idleCycle(1'b1);
        checkOutput("t1_oen_fetch", 32'(oen), 32'd0);
        idleCycle(1'b1);
        checkOutput("t1_oen_first", 32'(oen), 32'd1);
        drain("t1_drain", 20);
        checkOutput("t1_throughput", 32'(cyc), 32'(lastWr + 10));
        checkOutput("t1_hs", 32'(hsCount), 32'd8);
        checkOutput("t1_start", 32'(startCyc.size() > 0 ? startCyc[0] : -1), 32'(lastWr + 2));
        checkOutput("t1_oen_end", 32'(oen), 32'd0);
        checkOutput("t1_ovf", 32'(ovf), 32'd0);

        // Same frame under ordy pattern 1,0,0 repeating: beats held, none skipped.
        resetDut("rst2");
        expFrameQ.push_back(0);
        writeFrame(0, 1'b0);
        for (int k = 0; k < 60 && expFrameQ.size() > 0; k++) idleCycle(k % 3 == 0);
        checkOutput("t2_drain", 32'(expFrameQ.size()), 32'd0);
        checkOutput("t2_hs", 32'(hsCount), 32'd8);
        idleCycle(1'b1);
        checkOutput("t2_oen_end", 32'(oen), 32'd0);

        // Three frames; frame 2 completes on the same edge frame 1 drains,
        // frame 3 is written into bank 0 the cycle after it is freed.
        resetDut("rst3");
        expFrameQ.push_back(1);
        expFrameQ.push_back(2);
        expFrameQ.push_back(3);
        writeFrame(1, 1'b1);
        mark = lastWr;
        idleCycle(1'b1);
        idleCycle(1'b1);
        writeFrame(2, 1'b1);
        writeFrame(3, 1'b1);
        drain("t3_drain", 40);
        checkOutput("t3_hs", 32'(hsCount), 32'd24);
        checkOutput("t3_frames", 32'(startCyc.size()), 32'd3);
        if (startCyc.size() == 3) begin
            checkOutput("t3_start1", 32'(startCyc[0]), 32'(mark + 2));
            checkOutput("t3_gap12", 32'(startCyc[1]), 32'(startCyc[0] + 9));
            checkOutput("t3_gap23", 32'(startCyc[2]), 32'(startCyc[1] + 9));
        end
        checkOutput("t3_ovf", 32'(ovf), 32'd0);

        // Consumer stalled: frames 4 and 5 fill both banks, frame 6 overflows.
        resetDut("rst4");
        expFrameQ.push_back(4);
        expFrameQ.push_back(5);
        writeFrame(4, 1'b0);
        writeFrame(5, 1'b0);
        checkOutput("t4_ovf_before", 32'(ovf), 32'd0);
        writeFrame(6, 1'b0);
        checkOutput("t4_ovf_set", 32'(ovf), 32'd1);
        drain("t4_drain", 40);
        checkOutput("t4_hs", 32'(hsCount), 32'd16);
        for (int k = 0; k < 4; k++) idleCycle(1'b1);
        checkOutput("t4_oen_end", 32'(oen), 32'd0);
        checkOutput("t4_ovf_sticky", 32'(ovf), 32'd1);

        // Reset after a partial input frame and again in the middle of an output frame.
        resetDut("rst5");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(order[i]), expReal(6, order[i]), expImag(6, order[i]), 1'b1);
        end
        resetDut("rst5_midin");
        expFrameQ.push_back(7);
        writeFrame(7, 1'b1);
        for (int k = 0; k < 5; k++) idleCycle(1'b1);
        checkOutput("t5_midout_idx", 32'(oaddr), 32'd3);
        resetDut("rst5_midout");
        expFrameQ.push_back(8);
        writeFrame(8, 1'b1);
        drain("t5_drain", 20);
        checkOutput("t5_hs", 32'(hsCount), 32'd8);
        checkOutput("t5_start", 32'(startCyc.size() > 0 ? startCyc[0] : -1), 32'(lastWr + 2));
        checkOutput("t5_ovf", 32'(ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
